// File: rtl/codec_pkg.sv
// Shared I2S link constants and channel encoding, used by both the codec
// interface master and this codec-side responder.
package codec_pkg;

  localparam int DATA_W      = 16;
  localparam int MCLK_DIV    = 4;
  localparam int SCLK_DIV    = 32;
  localparam int LRCLK_DIV   = 1024;
  localparam int BITS_PER_CH = 16;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  // LRCLK low carries the left channel, high carries the right channel.
  function automatic channel_e lr_to_channel(input logic lrclk);
    return lrclk ? CH_RIGHT : CH_LEFT;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser with a history flop and single-cycle rise/fall strobes.
// Strobes stay masked until the history flop holds a real pin sample, so the
// reset level never shows up as an edge.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;
  logic [STAGES:0]   r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_hist <= RST_VAL;
      r_vld  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take its neighbour's
      // pre-edge value, which is what turns this into a shift chain.
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_hist <= r_sync[STAGES-1];
      r_vld  <= {r_vld[STAGES-1:0], 1'b1};
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_vld[STAGES] &  o_level & ~r_hist;
  assign o_fall  = r_vld[STAGES] & ~o_level &  r_hist;

endmodule

// File: rtl/i2s_codec_responder.sv
// Codec-side I2S endpoint: oversamples LRCLK/SCLK/SD_in, captures DAC words,
// serialises ADC words with the I2S one-bit delay and flags malformed half-frames.
module i2s_codec_responder
  import codec_pkg::*;
#(
  parameter int DATA_W      = codec_pkg::DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              LRCLK,
  input  logic              SCLK,
  input  logic              SD_in,
  input  logic [DATA_W-1:0] adc_left,
  input  logic [DATA_W-1:0] adc_right,
  output logic              adc_req,
  output logic              SD_out,
  output logic [DATA_W-1:0] dac_left,
  output logic [DATA_W-1:0] dac_right,
  output logic              dac_valid,
  output logic              sync_err
);

  localparam logic [4:0] C_BITS    = 5'(DATA_W);
  localparam logic [4:0] C_CNT_MAX = 5'd31;

  logic w_lr_level, w_lr_rise, w_lr_fall;
  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_sd_level, w_sd_rise, w_sd_fall;
  logic w_lr_edge;
  logic w_unused_edges;
  channel_e w_new_ch;
  logic [DATA_W-1:0] w_rx_next;

  logic [DATA_W-1:0] r_tx_shreg;
  logic              r_sd_out;
  logic              r_adc_req;
  logic [DATA_W-1:0] r_rx_shreg;
  logic [DATA_W-1:0] r_dac_left;
  logic [DATA_W-1:0] r_dac_right;
  logic              r_dac_valid;
  logic              r_pend_l;
  logic              r_pend_r;
  logic              r_have_left;
  logic [4:0]        r_bit_cnt;
  logic              r_armed;
  logic              r_sync_err;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_lr_sync (
    .clk(clk), .rst_n(rst_n), .i_pin(LRCLK),
    .o_level(w_lr_level), .o_rise(w_lr_rise), .o_fall(w_lr_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .i_pin(SCLK),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sd_sync (
    .clk(clk), .rst_n(rst_n), .i_pin(SD_in),
    .o_level(w_sd_level), .o_rise(w_sd_rise), .o_fall(w_sd_fall)
  );

  assign w_unused_edges = w_sclk_level | w_sd_rise | w_sd_fall;
  assign w_lr_edge      = w_lr_rise | w_lr_fall;
  assign w_new_ch       = lr_to_channel(w_lr_level);
  assign w_rx_next      = {r_rx_shreg[DATA_W-2:0], w_sd_level};

  // Transmit: the word loaded at an LRCLK edge starts leaving one SCLK fall later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shreg <= '0;
      r_sd_out   <= 1'b0;
      r_adc_req  <= 1'b0;
    end else begin
      r_adc_req <= 1'b0;
      if (w_sclk_fall) begin
        r_sd_out <= r_tx_shreg[DATA_W-1];
        if (w_lr_fall) begin
          r_tx_shreg <= adc_left;
          r_adc_req  <= 1'b1;
        end else if (w_lr_rise) begin
          r_tx_shreg <= adc_right;
        end else begin
          r_tx_shreg <= {r_tx_shreg[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  // Receive: the first SCLK rise after an LRCLK edge samples the finished word's LSB.
  // A right word only completes a pair if its left partner was captured this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_shreg  <= '0;
      r_dac_left  <= '0;
      r_dac_right <= '0;
      r_dac_valid <= 1'b0;
      r_pend_l    <= 1'b0;
      r_pend_r    <= 1'b0;
      r_have_left <= 1'b0;
    end else begin
      r_dac_valid <= 1'b0;
      if (w_sclk_rise) begin
        r_rx_shreg <= w_rx_next;
        if (r_pend_l) r_dac_left <= w_rx_next;
        if (r_pend_r) begin
          r_dac_right <= w_rx_next;
          r_dac_valid <= 1'b1;
        end
      end

      if (w_lr_edge && r_armed && w_new_ch == CH_RIGHT) r_pend_l <= 1'b1;
      else if (w_sclk_rise)                            r_pend_l <= 1'b0;

      if (w_lr_edge && r_have_left && w_new_ch == CH_LEFT) r_pend_r <= 1'b1;
      else if (w_sclk_rise)                                r_pend_r <= 1'b0;

      if (w_sclk_rise && r_pend_l)                r_have_left <= 1'b1;
      else if (w_lr_edge && w_new_ch == CH_LEFT)  r_have_left <= 1'b0;
    end
  end

  // Half-frame length check; the half-frame in progress at reset release is not judged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_armed    <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= 1'b0;
      if (w_lr_edge) begin
        r_bit_cnt <= '0;
        r_armed   <= 1'b1;
        if (r_armed && r_bit_cnt != C_BITS) r_sync_err <= 1'b1;
      end else if (w_sclk_rise && r_bit_cnt != C_CNT_MAX) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end
  end

  assign adc_req   = r_adc_req;
  assign SD_out    = r_sd_out;
  assign dac_left  = r_dac_left;
  assign dac_right = r_dac_right;
  assign dac_valid = r_dac_valid;
  assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_i2s_codec_responder.sv
// Self-checking bench: an I2S master model drives whole frames, and a frame-level
// model of expected DAC pairs, recovered ADC words and error pulses is compared at the end.
module tb_i2s_codec_responder;

  localparam int SYNC_STAGES = 2;
  localparam int DW          = 16;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    bit            dc;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          LRCLK, SCLK, SD_in;
  logic [DW-1:0] adc_left, adc_right;
  logic          adc_req, SD_out, dac_valid, sync_err;
  logic [DW-1:0] dac_left, dac_right;

  int checks = 0;
  int errors = 0;
  int n_err = 0;
  int err_frame = -1;
  int err_t = -1;
  bit tx_have = 1'b0;
  logic prev_r0 = 1'b0;
  logic [DW-1:0] tx_l, tx_r;
  pair_t exp_q[$], obs_q[$], txexp_q[$], tx_q[$];

  always #10 clk = ~clk;

  i2s_codec_responder #(.DATA_W(DW), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .LRCLK(LRCLK), .SCLK(SCLK), .SD_in(SD_in),
    .adc_left(adc_left), .adc_right(adc_right), .adc_req(adc_req),
    .SD_out(SD_out), .dac_left(dac_left), .dac_right(dac_right),
    .dac_valid(dac_valid), .sync_err(sync_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One 1024-clk frame: LRCLK falls with the SCLK fall at t=0 and rises at t=512.
  // skip_k holds SCLK high for that bit period; rst_t pulses rst_n low for 3 clk.
  task automatic run_frame(input int fidx, input logic [DW-1:0] dl, input logic [DW-1:0] dr,
                           input logic [DW-1:0] al, input logic [DW-1:0] ar,
                           input int skip_k, input int rst_t, input bit loopback, input bit flush);
    int n_req = 0;
    int req_t = -1;
    adc_left  = al;
    adc_right = ar;
    for (int t = 0; t < 1024; t++) begin
      int k, ph;
      bit skip;
      @(posedge clk); #1;
      k = t / 32;
      ph = t % 32;
      skip = (k == skip_k);
      if (t == rst_t) rst_n = 1'b0;
      if (rst_t >= 0 && t == rst_t + 3) rst_n = 1'b1;
      LRCLK = (t >= 512);
      SCLK  = skip ? 1'b1 : (ph >= 16);
      if (loopback && k != 0) SD_in = SD_out;
      else if (ph == 0) begin
        if (k == 0)       SD_in = prev_r0;
        else if (k <= 16) SD_in = dl[16-k];
        else              SD_in = dr[32-k];
      end
      @(negedge clk);
      if (t == rst_t)
        check("reset_mid_outputs", 64'({adc_req, SD_out, dac_left, dac_right, dac_valid, sync_err}), 64'd0);
      if (adc_req) begin
        n_req++;
        if (req_t < 0) req_t = t;
      end
      if (sync_err) begin
        n_err++;
        if (err_frame < 0) begin
          err_frame = fidx;
          err_t = t;
        end
      end
      if (dac_valid) obs_q.push_back('{l: dac_left, r: dac_right, dc: 1'b0});
      if (ph == 16 && !skip) begin
        if (k == 0) begin
          if (tx_have) begin
            tx_r[0] = SD_out;
            tx_q.push_back('{l: tx_l, r: tx_r, dc: 1'b0});
          end
        end else if (k <= 16) tx_l[16-k] = SD_out;
        else                  tx_r[32-k] = SD_out;
      end
    end
    tx_have = 1'b1;
    prev_r0 = dr[0];
    check($sformatf("adc_req_frame%0d", fidx), {32'(n_req), 32'(req_t)}, {32'd1, 32'(SYNC_STAGES + 1)});
    if (!flush) begin
      if (rst_t < 0) exp_q.push_back('{l: dl, r: dr, dc: (skip_k >= 0)});
      txexp_q.push_back('{l: al, r: ar, dc: (skip_k >= 0 || rst_t >= 0)});
    end
  endtask

  initial begin
    logic [DW-1:0] a, b, c, d, base_l, base_r;
    rst_n = 1'b0;
    LRCLK = 1'b1;
    SCLK = 1'b1;
    SD_in = 1'b0;
    adc_left = '0;
    adc_right = '0;
    repeat (3) @(negedge clk);
    check("reset_init_outputs", 64'({adc_req, SD_out, dac_left, dac_right, dac_valid, sync_err}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);

    run_frame(0, 16'hA5C3, 16'h1234, 16'h8001, 16'h7FFE, -1, -1, 1'b0, 1'b0);
    run_frame(1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, -1, -1, 1'b0, 1'b0);
    run_frame(2, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, -1, -1, 1'b0, 1'b0);
    for (int f = 3; f < 5; f++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      run_frame(f, a, b, c, d, -1, -1, 1'b0, 1'b0);
    end
    base_l = 16'($urandom);
    base_r = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      a = base_l + 16'(i);
      b = base_r + 16'(i);
      run_frame(5 + i, a, b, a, b, -1, -1, 1'b1, 1'b0);
    end
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    run_frame(13, a, b, c, d, 5, -1, 1'b0, 1'b0);
    for (int f = 14; f < 19; f++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      run_frame(f, a, b, c, d, -1, (f == 15) ? 256 : -1, 1'b0, (f == 18));
    end

    check("sync_err_count", 64'(n_err), 64'd1);
    check("sync_err_position", {32'(err_frame), 32'(err_t)}, {32'd13, 32'(512 + SYNC_STAGES + 1)});
    check("dac_pair_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (!exp_q[i].dc)
        check($sformatf("dac_pair%0d", i), 64'({obs_q[i].l, obs_q[i].r}), 64'({exp_q[i].l, exp_q[i].r}));
    check("tx_word_count", 64'(tx_q.size()), 64'(txexp_q.size()));
    for (int i = 0; i < tx_q.size() && i < txexp_q.size(); i++)
      if (!txexp_q[i].dc)
        check($sformatf("tx_pair%0d", i), 64'({tx_q[i].l, tx_q[i].r}), 64'({txexp_q[i].l, txexp_q[i].r}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
